// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable frame format, false-start filter and a show-ahead RX FIFO.
// Each FIFO entry carries the payload plus parity/framing error tags; drops when full raise overrun.
module uart_rx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 12,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             uart_rx,
    input  logic                             rd_en,
    input  logic                             clr_err,
    output logic [DATA_BITS-1:0]             rd_data,
    output logic                             rd_perr,
    output logic                             rd_ferr,
    output logic                             rd_valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
    output logic                             overrun,
    output logic                             busy
);

    localparam int unsigned CntW   = $clog2(CLKS_PER_BIT);
    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CountW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned EntryW = DATA_BITS + 2;

    localparam logic [CntW-1:0]   CntLast = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0]   CntMid  = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0]        BitLast = 4'(DATA_BITS - 1);
    localparam logic [CountW-1:0] Full    = CountW'(FIFO_DEPTH);
    localparam logic              OddPar  = (PARITY == 1);
    localparam logic              HasPar  = (PARITY != 0);
    localparam logic              OneStop = (STOP_BITS == 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StPar, StStop, StWaitHi} state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    state_e                 state_q;
    logic [CntW-1:0]        cnt_q;
    logic [3:0]             bit_q;
    logic                   stop_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   perr_q;
    logic                   ferr_q;

    logic [EntryW-1:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]        wr_ptr_q;
    logic [PtrW-1:0]        rd_ptr_q;
    logic [CountW-1:0]      count_q;
    logic                   overrun_q;

    logic                   sample;
    logic                   last_stop;
    logic                   push;
    logic [EntryW-1:0]      push_entry;
    logic                   pop;
    logic                   wr;
    logic                   drop;
    logic [EntryW-1:0]      head;

    assign rxs = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!reset) sync_q <= '1;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rx};
    end

    assign sample     = (cnt_q == CntLast);
    assign last_stop  = OneStop || stop_q;
    assign push       = (state_q == StStop) && sample && last_stop;
    // The final stop sample is folded in here so the push happens on the sampling edge.
    assign push_entry = {ferr_q | ~rxs, perr_q, shift_q};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    cnt_q  <= '0;
                    bit_q  <= '0;
                    stop_q <= 1'b0;
                    perr_q <= 1'b0;
                    ferr_q <= 1'b0;
                    if (!rxs) state_q <= StStart;
                end
                StStart: begin
                    if (cnt_q == CntMid) begin
                        cnt_q   <= '0;
                        state_q <= rxs ? StIdle : StData;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StData: begin
                    if (sample) begin
                        cnt_q   <= '0;
                        shift_q <= {rxs, shift_q[DATA_BITS-1:1]};
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == BitLast) state_q <= HasPar ? StPar : StStop;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StPar: begin
                    if (sample) begin
                        cnt_q   <= '0;
                        perr_q  <= ((^shift_q) ^ rxs) != OddPar;
                        state_q <= StStop;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StStop: begin
                    if (sample) begin
                        cnt_q <= '0;
                        if (!rxs) ferr_q <= 1'b1;
                        if (last_stop) state_q <= rxs ? StIdle : StWaitHi;
                        else           stop_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StWaitHi: begin
                    if (rxs) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign pop  = rd_en && (count_q != '0);
    assign wr   = push && ((count_q != Full) || pop);
    assign drop = push && (count_q == Full) && !pop;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (wr) begin
                mem_q[wr_ptr_q] <= push_entry;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (wr && !pop)      count_q <= count_q + 1'b1;
            else if (!wr && pop) count_q <= count_q - 1'b1;
            if (drop)         overrun_q <= 1'b1;
            else if (clr_err) overrun_q <= 1'b0;
        end
    end

    assign head       = mem_q[rd_ptr_q];
    assign rd_valid   = (count_q != '0);
    assign rd_data    = rd_valid ? head[DATA_BITS-1:0] : '0;
    assign rd_perr    = rd_valid ? head[DATA_BITS] : 1'b0;
    assign rd_ferr    = rd_valid ? head[DATA_BITS+1] : 1'b0;
    assign fifo_count = count_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != StIdle);

endmodule
